e203_ifu_bht: RTL and testbench
===============================

Name: e203_ifu_bht

Overview:
Gshare branch history table in the IFU. It supplies the taken/not-taken prediction for conditional branches (Bxx); that prediction travels down the pipe as the commit-stage bjp_prdt bit. The commit-stage branch resolver reports the resolved outcome of each committed Bxx back to this block, which trains its 2-bit counters and global history. The block also keeps branch and mispredict statistics counters.

Parameters:
PC_SIZE, 32, PC width (matches E203_PC_SIZE)
IDX_W, 6, table index width; entries = 2^IDX_W
GHR_W, 4, global history length; 1 <= GHR_W <= IDX_W
STAT_W, 32, statistics counter width

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
lkup_valid  input  1  IFU lookup for a Bxx instruction this cycle
lkup_pc  input  PC_SIZE  PC of the Bxx being looked up
lkup_prdt_taken  output  1  prediction, combinational in the same cycle
upd_valid  input  1  a committed Bxx handshake (valid & ready at commit)
upd_pc  input  PC_SIZE  PC of the committed Bxx
upd_taken  input  1  resolved outcome (bjp_rslv)
upd_mispred  input  1  prdt ^ rslv for this branch
bht_clr  input  1  synchronous clear of table and history
ghr_r  output  GHR_W  current global history
stat_br_cnt  output  STAT_W  committed Bxx count
stat_mis_cnt  output  STAT_W  mispredicted Bxx count

Behaviour:
- Counter encoding: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T. Prediction = counter[1].
- Index = pc[IDX_W:1] XOR {zero-extended ghr_r}. Bit 0 is ignored because RVC PCs are 2-byte aligned.
- Reset (async): every counter = 01, ghr_r = 0, the pending-update stage is invalid, both stats = 0. As a result, lkup_prdt_taken = 0 after reset.
- Lookup: purely combinational from the current table, ghr_r and bypass. No state changes. lkup_valid only qualifies the debug/assert checks.
- Update pipeline, 2 stages:
  - Stage 1 (edge after upd_valid): latch pend_vld = 1, pend_idx (computed from upd_pc and the pre-update ghr_r), and pend_ctr_new. pend_ctr_new is the saturating increment of the current entry if upd_taken, else the saturating decrement. The current entry is read through the bypass.
  - Stage 1 also shifts history: ghr_r <= {ghr_r[GHR_W-2:0], upd_taken}.
  - Stage 2 (following edge): table[pend_idx] <= pend_ctr_new. pend_vld clears unless a new upd_valid arrives that cycle.
  - Throughput is one update per cycle. Back-to-back updates to the same index must chain correctly: the second update reads the first's pend_ctr_new through the bypass.
- Bypass: if pend_vld and pend_idx equals the lookup or update index, use pend_ctr_new instead of the table entry.
- Saturation: 11 plus taken stays 11; 00 plus not-taken stays 00.
- Simultaneous lookup and upd_valid in the same cycle: the lookup sees the old ghr_r and the old table (plus any earlier pending bypass). It does not see the current update.
- bht_clr: on the next edge, all counters = 01, ghr_r = 0, pend_vld = 0. Clear wins over a same-cycle upd_valid and over a pending write. Stats are not affected by bht_clr.
- Stats: on upd_valid, stat_br_cnt increments by 1. If upd_mispred is also set, stat_mis_cnt increments by 1. Both saturate at all-ones and never wrap. Both are cleared only by rst_n.
- Reset mid-operation: any pending write is discarded and all state returns to reset values immediately (async).
- Table storage is flops, not SRAM, so the zero-latency read and async reset are possible. The implementation must not contain a combinational loop from upd_* to lkup_prdt_taken.

Test Plan:
1. Reset (GHR_W=4, IDX_W=6) → lookup any pc gives lkup_prdt_taken = 0, ghr_r = 0, stats = 0.
2. Single update: upd_pc=0x80000010, taken=1. Entry idx 0x08 goes 01→10. ghr_r = 0001 after one edge. Lookup of pc 0x80000010 (idx 0x08^0x1 = 0x09) predicts 0. Lookup of pc 0x8000000E (idx 0x07^0x1 = 0x06) predicts 0.
3. Saturation with stable history (clear ghr between updates via PCs chosen so the index is constant): apply taken ×4 to one index → counter reaches 11. Apply not-taken ×1 → 10, still predicts 1. Apply not-taken ×3 → 00 and stays 00.
4. Back-to-back same-index updates on consecutive cycles (taken, taken) from 01 → final counter 11, proving the bypass chain. A lookup of that index in the cycle between the two writes returns 1.
5. bht_clr asserted in the same cycle as upd_valid → all entries 01, ghr_r = 0, no write lands. stat_br_cnt still increments by 1.
6. Stats: 10 updates, 3 with upd_mispred → stat_br_cnt = 10, stat_mis_cnt = 3. Preload near saturation (STAT_W=4): 16 updates → stat_br_cnt holds at 15.

Source files
------------

// File: rtl/e203_ifu_bht.sv
// Gshare branch history table: 2-bit counters indexed by pc ^ global history,
// with a two-stage training pipeline and saturating branch/mispredict statistics.
module e203_ifu_bht #(
    parameter int PC_SIZE = 32,
    parameter int IDX_W   = 6,
    parameter int GHR_W   = 4,
    parameter int STAT_W  = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               lkup_valid,
    input  logic [PC_SIZE-1:0] lkup_pc,
    output logic               lkup_prdt_taken,
    input  logic               upd_valid,
    input  logic [PC_SIZE-1:0] upd_pc,
    input  logic               upd_taken,
    input  logic               upd_mispred,
    input  logic               bht_clr,
    output logic [GHR_W-1:0]   ghr_r,
    output logic [STAT_W-1:0]  stat_br_cnt,
    output logic [STAT_W-1:0]  stat_mis_cnt
);

    localparam int          ENTRIES  = 1 << IDX_W;
    localparam logic [1:0]  CTR_INIT = 2'b01;

    logic [1:0]       bht [ENTRIES];
    logic             pend_vld;
    logic [IDX_W-1:0] pend_idx;
    logic [1:0]       pend_ctr_new;

    logic [IDX_W-1:0] lkup_idx;
    logic [IDX_W-1:0] upd_idx;
    logic [1:0]       lkup_ctr;
    logic [1:0]       upd_ctr_cur;
    logic [1:0]       upd_ctr_new;
    logic [GHR_W-1:0] ghr_next;

    // Bits outside the index window carry no information for the hash.
    logic unused_ok;
    assign unused_ok = ^{lkup_valid, lkup_pc[0], lkup_pc[PC_SIZE-1:IDX_W+1],
                         upd_pc[0], upd_pc[PC_SIZE-1:IDX_W+1]};

    // NOTE: every signal written here gets a default first so no latch is inferred.
    always_comb begin
        lkup_idx    = lkup_pc[IDX_W:1] ^ IDX_W'(ghr_r);
        upd_idx     = upd_pc[IDX_W:1] ^ IDX_W'(ghr_r);
        lkup_ctr    = bht[lkup_idx];
        upd_ctr_cur = bht[upd_idx];
        // The not-yet-written counter is visible through the bypass, so the
        // table behaves as if every update landed on the first edge.
        if (pend_vld && (pend_idx == lkup_idx)) lkup_ctr    = pend_ctr_new;
        if (pend_vld && (pend_idx == upd_idx))  upd_ctr_cur = pend_ctr_new;
        upd_ctr_new = upd_ctr_cur;
        if (upd_taken && (upd_ctr_cur != 2'b11))       upd_ctr_new = upd_ctr_cur + 2'd1;
        else if (!upd_taken && (upd_ctr_cur != 2'b00)) upd_ctr_new = upd_ctr_cur - 2'd1;
        // Truncating {ghr, taken} drops the oldest bit and also works for GHR_W == 1.
        ghr_next = GHR_W'({ghr_r, upd_taken});
    end

    assign lkup_prdt_taken = lkup_ctr[1];

    // NOTE: the counter array is flop-based, so it can take the async reset like any register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) bht[i] <= CTR_INIT;
        end else if (bht_clr) begin
            for (int i = 0; i < ENTRIES; i++) bht[i] <= CTR_INIT;
        end else if (pend_vld) begin
            bht[pend_idx] <= pend_ctr_new;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_vld     <= 1'b0;
            pend_idx     <= '0;
            pend_ctr_new <= CTR_INIT;
            ghr_r        <= '0;
        end else if (bht_clr) begin
            pend_vld <= 1'b0;
            ghr_r    <= '0;
        end else begin
            pend_vld <= upd_valid;
            if (upd_valid) begin
                pend_idx     <= upd_idx;
                pend_ctr_new <= upd_ctr_new;
                ghr_r        <= ghr_next;
            end
        end
    end

    // Statistics ignore bht_clr and saturate instead of wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_br_cnt  <= '0;
            stat_mis_cnt <= '0;
        end else if (upd_valid) begin
            if (stat_br_cnt != '1) stat_br_cnt <= stat_br_cnt + STAT_W'(1);
            if (upd_mispred && (stat_mis_cnt != '1)) stat_mis_cnt <= stat_mis_cnt + STAT_W'(1);
        end
    end

endmodule

// File: tb/tb_e203_ifu_bht.sv
// Self-checking bench for e203_ifu_bht: directed scenarios plus a randomized run
// against an architectural gshare model where each update takes effect at its edge.
module tb_e203_ifu_bht;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        lkup_valid = 1'b0;
    logic [31:0] lkup_pc = '0;
    logic        upd_valid = 1'b0;
    logic [31:0] upd_pc = '0;
    logic        upd_taken = 1'b0;
    logic        upd_mispred = 1'b0;
    logic        bht_clr = 1'b0;

    logic        pred, pred4;
    logic [3:0]  ghr, ghr4;
    logic [31:0] br, mis;
    logic [3:0]  br4, mis4;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int m_ctr[64];
    int m_ghr;
    int m_br, m_mis;

    e203_ifu_bht #(.PC_SIZE(32), .IDX_W(6), .GHR_W(4), .STAT_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .lkup_valid(lkup_valid), .lkup_pc(lkup_pc),
        .lkup_prdt_taken(pred), .upd_valid(upd_valid), .upd_pc(upd_pc),
        .upd_taken(upd_taken), .upd_mispred(upd_mispred), .bht_clr(bht_clr),
        .ghr_r(ghr), .stat_br_cnt(br), .stat_mis_cnt(mis)
    );

    e203_ifu_bht #(.PC_SIZE(32), .IDX_W(6), .GHR_W(4), .STAT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .lkup_valid(lkup_valid), .lkup_pc(lkup_pc),
        .lkup_prdt_taken(pred4), .upd_valid(upd_valid), .upd_pc(upd_pc),
        .upd_taken(upd_taken), .upd_mispred(upd_mispred), .bht_clr(bht_clr),
        .ghr_r(ghr4), .stat_br_cnt(br4), .stat_mis_cnt(mis4)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, required finish before 1000000");
        $fatal(1, "watchdog");
    end

    function automatic int m_idx(input logic [31:0] pc);
        return ((pc >> 1) & 63) ^ m_ghr;
    endfunction

    function automatic logic m_pred(input logic [31:0] pc);
        return (m_ctr[m_idx(pc)] >= 2) ? 1'b1 : 1'b0;
    endfunction

    function automatic logic [31:0] pc_for(input int idx);
        return 32'h8000_0000 | 32'(((idx ^ m_ghr) & 63) << 1);
    endfunction

    function automatic int sat15(input int v);
        return (v > 15) ? 15 : v;
    endfunction

    task automatic m_clear_table();
        for (int i = 0; i < 64; i++) m_ctr[i] = 1;
        m_ghr = 0;
    endtask

    task automatic m_reset();
        m_clear_table();
        m_br  = 0;
        m_mis = 0;
    endtask

    // One clock edge; the model consumes the inputs that the DUT sampled.
    task automatic tick();
        int i;
        @(posedge clk);
        if (upd_valid) begin
            m_br++;
            if (upd_mispred) m_mis++;
        end
        if (bht_clr) begin
            m_clear_table();
        end else if (upd_valid) begin
            i = m_idx(upd_pc);
            if (upd_taken && m_ctr[i] < 3) m_ctr[i]++;
            else if (!upd_taken && m_ctr[i] > 0) m_ctr[i]--;
            m_ghr = ((m_ghr << 1) | (upd_taken ? 1 : 0)) & 15;
        end
        #1;
    endtask

    task automatic idle();
        upd_valid   = 1'b0;
        upd_taken   = 1'b0;
        upd_mispred = 1'b0;
        bht_clr     = 1'b0;
    endtask

    task automatic apply(input int idx, input logic taken);
        upd_valid = 1'b1;
        upd_pc    = pc_for(idx);
        upd_taken = taken;
        tick();
        idle();
    endtask

    task automatic test_reset();
        logic [31:0] pcs [3];
        pcs[0] = 32'h8000_0000; pcs[1] = 32'h8000_0010; pcs[2] = 32'h8000_007E;
        lkup_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            lkup_pc = pcs[k];
            #1;
            checks++;
            if (pred !== 1'b0) begin
                errors++;
                $display("FAIL reset_pred pc=%h: got %b, want 0", pcs[k], pred);
            end
        end
        checks++;
        if (ghr !== 4'd0 || br !== 32'd0 || mis !== 32'd0) begin
            errors++;
            $display("FAIL reset_state: ghr=%h br=%0d mis=%0d, want 0 0 0", ghr, br, mis);
        end
    endtask

    task automatic test_single_update();
        @(posedge clk); #1;
        upd_valid = 1'b1; upd_pc = 32'h8000_0010; upd_taken = 1'b1;
        tick();
        idle();
        checks++;
        if (ghr !== 4'b0001) begin
            errors++;
            $display("FAIL single_ghr: got %b, want 0001", ghr);
        end
        lkup_pc = 32'h8000_0010; #1;
        checks++;
        if (pred !== 1'b0) begin
            errors++;
            $display("FAIL single_pred_idx09: got %b, want 0", pred);
        end
        lkup_pc = 32'h8000_000E; #1;
        checks++;
        if (pred !== 1'b0) begin
            errors++;
            $display("FAIL single_pred_idx06: got %b, want 0", pred);
        end
        // pc 0x12 hashes to index 0x08, the trained entry (now 10), via the bypass
        lkup_pc = 32'h8000_0012; #1;
        checks++;
        if (pred !== 1'b1) begin
            errors++;
            $display("FAIL single_pred_idx08_bypass: got %b, want 1", pred);
        end
        tick();
        checks++;
        if (pred !== 1'b1) begin
            errors++;
            $display("FAIL single_pred_idx08_table: got %b, want 1", pred);
        end
    endtask

    task automatic test_saturation();
        for (int k = 0; k < 4; k++) apply(32, 1'b1);
        lkup_pc = pc_for(32); #1;
        checks++;
        if (pred !== 1'b1) begin
            errors++;
            $display("FAIL sat_up_x4: got %b, want 1", pred);
        end
        apply(32, 1'b0);
        lkup_pc = pc_for(32); #1;
        checks++;
        if (pred !== 1'b1) begin
            errors++;
            $display("FAIL sat_down_x1: got %b, want 1 (counter 10)", pred);
        end
        for (int k = 0; k < 3; k++) apply(32, 1'b0);
        apply(32, 1'b1);
        lkup_pc = pc_for(32); #1;
        checks++;
        if (pred !== 1'b0) begin
            errors++;
            $display("FAIL sat_floor_then_up: got %b, want 0 (counter 01)", pred);
        end
        apply(32, 1'b1);
        lkup_pc = pc_for(32); #1;
        checks++;
        if (pred !== 1'b1) begin
            errors++;
            $display("FAIL sat_floor_then_up2: got %b, want 1 (counter 10)", pred);
        end
    endtask

    task automatic test_back_to_back();
        bht_clr = 1'b1;
        tick();
        idle();
        upd_valid = 1'b1; upd_pc = pc_for(21); upd_taken = 1'b1;
        lkup_pc = pc_for(21); #1;
        checks++;
        if (pred !== 1'b0) begin
            errors++;
            $display("FAIL b2b_same_cycle_lookup: got %b, want 0", pred);
        end
        tick();
        upd_pc = pc_for(21); upd_taken = 1'b1;
        lkup_pc = pc_for(21); #1;
        checks++;
        if (pred !== 1'b1) begin
            errors++;
            $display("FAIL b2b_between_writes: got %b, want 1", pred);
        end
        tick();
        idle();
        tick();
        apply(21, 1'b0);
        lkup_pc = pc_for(21); #1;
        checks++;
        if (pred !== 1'b1) begin
            errors++;
            $display("FAIL b2b_chain_reached_11: got %b, want 1 (11 then not-taken)", pred);
        end
    endtask

    task automatic test_clear();
        int br_before;
        apply(42, 1'b1);
        br_before = m_br;
        upd_valid = 1'b1; upd_pc = pc_for(43); upd_taken = 1'b1; bht_clr = 1'b1;
        tick();
        idle();
        checks++;
        if (ghr !== 4'd0) begin
            errors++;
            $display("FAIL clr_ghr: got %b, want 0000", ghr);
        end
        checks++;
        if (br !== 32'(br_before + 1)) begin
            errors++;
            $display("FAIL clr_stat_br: got %0d, want %0d", br, br_before + 1);
        end
        tick();
        for (int k = 42; k <= 43; k++) begin
            lkup_pc = pc_for(k); #1;
            checks++;
            if (pred !== 1'b0) begin
                errors++;
                $display("FAIL clr_entry idx=%0d: got %b, want 0", k, pred);
            end
        end
    endtask

    task automatic test_stats();
        @(posedge clk); #2;
        rst_n = 1'b0; #2;
        rst_n = 1'b1;
        m_reset();
        @(posedge clk); #1;
        for (int k = 0; k < 10; k++) begin
            upd_valid = 1'b1; upd_pc = 32'h8000_0000 | ($urandom & 32'h7E);
            upd_taken = $urandom_range(0, 1) == 1;
            upd_mispred = (k == 2 || k == 5 || k == 8);
            tick();
        end
        idle();
        checks++;
        if (br !== 32'd10 || mis !== 32'd3) begin
            errors++;
            $display("FAIL stats_10_3: got br=%0d mis=%0d, want 10 3", br, mis);
        end
        checks++;
        if (br4 !== 4'd10 || mis4 !== 4'd3) begin
            errors++;
            $display("FAIL stats4_10_3: got br=%0d mis=%0d, want 10 3", br4, mis4);
        end
        for (int k = 0; k < 16; k++) begin
            upd_valid = 1'b1; upd_pc = 32'h8000_0000 | ($urandom & 32'h7E);
            upd_taken = $urandom_range(0, 1) == 1; upd_mispred = 1'b1;
            tick();
        end
        idle();
        checks++;
        if (br4 !== 4'd15 || mis4 !== 4'd15) begin
            errors++;
            $display("FAIL stats4_saturate: got br=%0d mis=%0d, want 15 15", br4, mis4);
        end
        checks++;
        if (br !== 32'd26 || mis !== 32'd19) begin
            errors++;
            $display("FAIL stats_26_19: got br=%0d mis=%0d, want 26 19", br, mis);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            upd_valid   = $urandom_range(0, 9) < 6;
            upd_pc      = 32'h8000_0000 | ($urandom & 32'h0000_FF80)
                          | 32'($urandom_range(0, 15) << 1) | 32'($urandom_range(0, 1));
            upd_taken   = $urandom_range(0, 1) == 1;
            upd_mispred = $urandom_range(0, 1) == 1;
            bht_clr     = $urandom_range(0, 49) == 0;
            lkup_pc     = 32'h8000_0000 | 32'($urandom_range(0, 31) << 1);
            #1;
            checks++;
            if (pred !== m_pred(lkup_pc) || pred4 !== m_pred(lkup_pc)) begin
                errors++;
                $display("FAIL rand_pred n=%0d pc=%h: got %b/%b, want %b",
                         n, lkup_pc, pred, pred4, m_pred(lkup_pc));
            end
            tick();
            checks++;
            if (ghr !== 4'(m_ghr) || ghr4 !== 4'(m_ghr) || br !== 32'(m_br) || mis !== 32'(m_mis)
                || br4 !== 4'(sat15(m_br)) || mis4 !== 4'(sat15(m_mis))) begin
                errors++;
                $display("FAIL rand_state n=%0d: got ghr=%h br=%0d mis=%0d br4=%0d mis4=%0d, want ghr=%h br=%0d mis=%0d br4=%0d mis4=%0d",
                         n, ghr, br, mis, br4, mis4, m_ghr, m_br, m_mis, sat15(m_br), sat15(m_mis));
            end
        end
        idle();
    endtask

    task automatic test_reset_midop();
        apply(60, 1'b1);
        #2;
        rst_n = 1'b0;
        m_reset();
        #1;
        lkup_pc = pc_for(60); #1;
        checks++;
        if (ghr !== 4'd0 || br !== 32'd0 || mis !== 32'd0 || pred !== 1'b0) begin
            errors++;
            $display("FAIL midop_reset_async: got ghr=%h br=%0d mis=%0d pred=%b, want 0 0 0 0",
                     ghr, br, mis, pred);
        end
        rst_n = 1'b1;
        tick();
        tick();
        checks++;
        if (pred !== 1'b0) begin
            errors++;
            $display("FAIL midop_pending_discarded: got %b, want 0", pred);
        end
    endtask

    initial begin
        m_reset();
        #12;
        rst_n = 1'b1;
        test_reset();
        test_single_update();
        test_saturation();
        test_back_to_back();
        test_clear();
        test_stats();
        test_random();
        test_reset_midop();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
